// File: rtl/grayscale_pipe.sv
// grayscale_pipe: streaming RGB-to-grayscale converter between two FWFT FIFOs.
// Two register stages (S1 = channel sum/products + mode, OUT = gray value)
// advance together whenever OUT is empty or the output FIFO can accept a write.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   mode[1:0]        per-pixel conversion: 0=avg, 1=luma, 2=max, 3=avg
//   fifo_in_*        input FIFO pop/data/empty (rd_en combinational)
//   fifo_out_*       output FIFO push/data/full (wr_en combinational, din registered)
//
// Optional build macro GRAYSCALE_STATS_EN adds pixel_count / stall_count.
module grayscale_pipe #(
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned RESET_MODE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic                  fifo_in_rd_en,
  input  logic [3*CH_WIDTH-1:0] fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [CH_WIDTH-1:0]   fifo_out_din,
  input  logic                  fifo_out_full
`ifdef GRAYSCALE_STATS_EN
  ,
  output logic [31:0]           pixel_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int unsigned PIX_W = 3 * CH_WIDTH;
  localparam int unsigned SUM_W = CH_WIDTH + 2;
  localparam int unsigned VAL_W = CH_WIDTH + 9;

  localparam logic [1:0] MODE_LUMA = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;

  localparam logic [CH_WIDTH-1:0] CH_MAX = '1;

  logic                s1_valid;
  logic [VAL_W-1:0]    s1_val;
  logic [1:0]          s1_mode;
  logic                out_valid;
  logic                advance;

  logic [CH_WIDTH-1:0] ch_r, ch_g, ch_b, ch_max;
  logic [VAL_W-1:0]    s1_next;
  logic [SUM_W-1:0]    avg_sum, avg_q;
  logic [VAL_W-1:0]    luma_q;
  logic [CH_WIDTH-1:0] gray_next;

  // Pipeline moves only when OUT is free or will be drained this cycle.
  assign advance        = ~out_valid | ~fifo_out_full;
  assign fifo_in_rd_en  = ~fifo_in_empty & advance & ~reset;
  assign fifo_out_wr_en = out_valid & ~fifo_out_full;

  // Stage 1 compute: one shared value register holds sum, weighted sum or max.
  always_comb begin
    ch_r    = fifo_in_dout[PIX_W-1 -: CH_WIDTH];
    ch_g    = fifo_in_dout[2*CH_WIDTH-1 -: CH_WIDTH];
    ch_b    = fifo_in_dout[CH_WIDTH-1:0];
    ch_max  = ch_r;
    s1_next = '0;
    if (ch_g > ch_max) ch_max = ch_g;
    if (ch_b > ch_max) ch_max = ch_b;
    case (mode)
      MODE_LUMA: s1_next = VAL_W'(77)  * VAL_W'(ch_r)
                         + VAL_W'(150) * VAL_W'(ch_g)
                         + VAL_W'(29)  * VAL_W'(ch_b)
                         + VAL_W'(128);
      MODE_MAX:  s1_next = VAL_W'(ch_max);
      default:   s1_next = VAL_W'(SUM_W'(ch_r) + SUM_W'(ch_g) + SUM_W'(ch_b));
    endcase
  end

  // Stage 2 finish: exact divide-by-3 for avg, rounding shift + saturate for luma.
  always_comb begin
    avg_sum   = s1_val[SUM_W-1:0];
    avg_q     = avg_sum / SUM_W'(3);
    luma_q    = s1_val >> 8;
    gray_next = CH_WIDTH'(avg_q);
    case (s1_mode)
      MODE_LUMA: gray_next = (luma_q > VAL_W'(CH_MAX)) ? CH_MAX : CH_WIDTH'(luma_q);
      MODE_MAX:  gray_next = CH_WIDTH'(s1_val);
      default:   gray_next = CH_WIDTH'(avg_q);
    endcase
  end

  // Pipeline registers; both stages hold together on a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_val       <= '0;
      s1_mode      <= 2'(RESET_MODE);
      out_valid    <= 1'b0;
      fifo_out_din <= '0;
    end else if (advance) begin
      s1_valid     <= fifo_in_rd_en;
      s1_val       <= s1_next;
      s1_mode      <= mode;
      out_valid    <= s1_valid;
      fifo_out_din <= gray_next;
    end
  end

`ifdef GRAYSCALE_STATS_EN
  // Free-running wrap-around counters of written pixels and stalled cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_count <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_out_wr_en)            pixel_count <= pixel_count + 32'd1;
      if (out_valid & fifo_out_full) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed bench for grayscale_pipe: input FIFO modelled as a pixel/mode table,
// output FIFO as a capture queue with write cycle stamps.
module tb_grayscale_pipe;

  localparam int unsigned W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     mode;
  logic           fifo_in_rd_en;
  logic [3*W-1:0] fifo_in_dout;
  logic           fifo_in_empty;
  logic           fifo_out_wr_en;
  logic [W-1:0]   fifo_out_din;
  logic           fifo_out_full;
`ifdef GRAYSCALE_STATS_EN
  logic [31:0]    pixel_count;
  logic [31:0]    stall_count;
`endif

  grayscale_pipe #(.CH_WIDTH(W), .RESET_MODE(0)) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full)
`ifdef GRAYSCALE_STATS_EN
    ,
    .pixel_count    (pixel_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clock = ~clock;

  logic [3*W-1:0] pix_mem  [0:255];
  logic [1:0]     mode_mem [0:255];
  int             pop_cyc  [0:255];
  logic [7:0]     rd_ptr = 8'd0;
  logic [7:0]     wr_ptr = 8'd0;
  logic           hold_empty = 1'b0;
  int             cyc = 0;
  logic [W-1:0]   out_q[$];
  int             out_cyc[$];
  int             errors = 0;
  int             checks = 0;

  assign fifo_in_dout  = pix_mem[rd_ptr];
  assign mode          = mode_mem[rd_ptr];
  assign fifo_in_empty = hold_empty || (rd_ptr == wr_ptr);

  // FIFO models: pop on rd_en, capture on wr_en.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_in_rd_en) begin
      pop_cyc[rd_ptr] <= cyc;
      rd_ptr          <= rd_ptr + 8'd1;
    end
    if (fifo_out_wr_en) begin
      out_q.push_back(fifo_out_din);
      out_cyc.push_back(cyc);
    end
  end

  task automatic push_pix(input logic [3*W-1:0] p, input logic [1:0] m);
    pix_mem[wr_ptr]  = p;
    mode_mem[wr_ptr] = m;
    wr_ptr           = wr_ptr + 8'd1;
  endtask

  task automatic clear_out();
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (out_q.size() < n) begin
      errors++; checks++;
      $display("FAIL wait_out: got %0d outputs, required %0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fifo_out_full = 1'b0; hold_empty = 1'b0;
    clear_out();
    push_pix(24'h0A0B0C, 2'd0);
    repeat (2) @(negedge clock);
    checks++; if (fifo_in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_in_rd_en); end
    checks++; if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", fifo_out_wr_en); end
    checks++; if (fifo_out_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h, required 00", fifo_out_din); end
    reset = 1'b0;
    wait_out(1, 10);
    // (10+11+12)/3 = 11
    checks++; if (out_q.size() > 0 && out_q[0] !== 8'h0B) begin errors++; $display("FAIL first_pixel: got %h, required 0b", out_q[0]); end
    repeat (4) @(negedge clock);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL bubbles: got %0d writes, required 1", out_q.size()); end
  endtask

  task automatic test_avg();
    logic [W-1:0] exp_v [3] = '{8'h20, 8'hFF, 8'h00};
    logic [7:0] base = rd_ptr;
    clear_out();
    push_pix(24'h102030, 2'd0);
    push_pix(24'hFFFFFF, 2'd0);
    push_pix(24'h000001, 2'd0);
    wait_out(3, 20);
    for (int i = 0; i < 3; i++) begin
      if (i < out_q.size()) begin
        checks++; if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL avg_%0d: got %h, required %h", i, out_q[i], exp_v[i]); end
        checks++; if (out_cyc[i] - pop_cyc[8'(base + 8'(i))] != 2) begin errors++;
          $display("FAIL avg_latency_%0d: got %0d, required 2", i, out_cyc[i] - pop_cyc[8'(base + 8'(i))]); end
      end
    end
  endtask

  task automatic test_luma();
    // 150*255+128 = 38378 -> 149 after >>8
    logic [W-1:0] exp_v [4] = '{8'h4D, 8'h95, 8'h1D, 8'hFF};
    clear_out();
    push_pix(24'hFF0000, 2'd1);
    push_pix(24'h00FF00, 2'd1);
    push_pix(24'h0000FF, 2'd1);
    push_pix(24'hFFFFFF, 2'd1);
    wait_out(4, 20);
    for (int i = 0; i < 4; i++)
      if (i < out_q.size()) begin
        checks++; if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL luma_%0d: got %h, required %h", i, out_q[i], exp_v[i]); end
      end
  endtask

  task automatic test_max_and_mode_mix();
    // Mode changes every pixel: max, reserved(avg), luma, max.
    logic [W-1:0] exp_v [4] = '{8'hF0, 8'h03, 8'h4D, 8'hFE};
    clear_out();
    push_pix(24'h12F034, 2'd2);
    push_pix(24'h030303, 2'd3);
    push_pix(24'hFF0000, 2'd1);
    push_pix(24'h0100FE, 2'd2);
    wait_out(4, 20);
    for (int i = 0; i < 4; i++)
      if (i < out_q.size()) begin
        checks++; if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL mode_%0d: got %h, required %h", i, out_q[i], exp_v[i]); end
      end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held;
    int k = 0;
    clear_out();
    // Gray pixels {v,v,v} average to v.
    for (int i = 1; i <= 8; i++) push_pix({3{8'(i)}}, 2'd0);
    while (out_q.size() < 2 && k < 20) begin @(negedge clock); k++; end
    fifo_out_full = 1'b1;
    #1;
    held = fifo_out_din;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clock); #1; end
      checks++; if (fifo_in_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en_%0d: got %b, required 0", c, fifo_in_rd_en); end
      checks++; if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en_%0d: got %b, required 0", c, fifo_out_wr_en); end
      checks++; if (fifo_out_din !== held) begin errors++; $display("FAIL stall_din_%0d: got %h, required %h", c, fifo_out_din, held); end
    end
    @(negedge clock);
    fifo_out_full = 1'b0;
    #1;
    checks++; if (fifo_out_wr_en !== 1'b1) begin errors++; $display("FAIL resume_wr_en: got %b, required 1", fifo_out_wr_en); end
    wait_out(8, 40);
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL stream_count: got %0d, required 8", out_q.size()); end
    for (int i = 0; i < 8; i++)
      if (i < out_q.size()) begin
        checks++; if (out_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_%0d: got %h, required %h", i, out_q[i], 8'(i + 1)); end
      end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] base = rd_ptr;
    int k = 0;
    int n;
    clear_out();
    for (int i = 0; i < 6; i++) push_pix(24'h404040, 2'd0);
    while (8'(rd_ptr - base) < 8'd2 && k < 20) begin @(negedge clock); k++; end
    reset  = 1'b1;
    wr_ptr = rd_ptr;
    @(negedge clock);
    checks++; if (fifo_out_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr_en: got %b, required 0", fifo_out_wr_en); end
    checks++; if (fifo_out_din !== 8'h00) begin errors++; $display("FAIL mid_reset_din: got %h, required 00", fifo_out_din); end
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL mid_reset_writes: got %0d, required 1", out_q.size()); end
    n = out_q.size();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (out_q.size() != n) begin errors++; $display("FAIL stale_after_reset: got %0d writes, required %0d", out_q.size(), n); end
  endtask

`ifdef GRAYSCALE_STATS_EN
  task automatic test_stats();
    int k = 0;
    reset = 1'b1;
    clear_out();
    repeat (2) @(negedge clock);
    checks++; if (pixel_count !== 32'd0) begin errors++; $display("FAIL stats_reset_pix: got %0d, required 0", pixel_count); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL stats_reset_stall: got %0d, required 0", stall_count); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) push_pix(24'h010203, 2'd0);
    while (out_q.size() < 2 && k < 20) begin @(negedge clock); k++; end
    fifo_out_full = 1'b1;
    repeat (3) @(negedge clock);
    fifo_out_full = 1'b0;
    wait_out(10, 40);
    repeat (2) @(negedge clock);
    checks++; if (pixel_count !== 32'd10) begin errors++; $display("FAIL stats_pix: got %0d, required 10", pixel_count); end
    checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL stats_stall: got %0d, required 3", stall_count); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (pixel_count !== 32'd0) begin errors++; $display("FAIL stats_clear_pix: got %0d, required 0", pixel_count); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL stats_clear_stall: got %0d, required 0", stall_count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    fifo_out_full = 1'b0;
    @(negedge clock);
    test_reset();
    test_avg();
    test_luma();
    test_max_and_mode_mix();
    test_back_to_back();
    test_reset_midstream();
`ifdef GRAYSCALE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
